// File: rtl/v_shift_tx_8.sv
// ---------------------------------------------------------------------------
// v_shift_tx_8 -- serial frame transmitter
//
// Shifts a parallel word out on one idle-high line as a frame:
//   start bit (0), WIDTH data bits LSB first, optional even-parity bit,
//   stop bit (1). Each bit is held on Q for BIT_CYCLES clock cycles.
//
// Build option:
//   TX_PARITY_EN  when defined, a PAR state inserts one even-parity bit
//                 between the last data bit and the stop bit.
//
// Parameters:
//   WIDTH       data bits per frame (1..32)
//   BIT_CYCLES  clock cycles each bit is held on Q (>= 1)
//
// Ports:
//   C     in   clock, rising edge
//   CLR   in   asynchronous active-high reset; aborts any frame in flight
//   LOAD  in   start request, sampled on the rising edge of C
//   DIN   in   parallel data, captured only on the accepting edge
//   Q     out  serial line, idles high (registered)
//   BUSY  out  high while a frame is in progress (registered)
//   DONE  out  one-cycle pulse when a frame completes (registered)
// ---------------------------------------------------------------------------
module v_shift_tx_8 #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIN,
  output logic             Q,
  output logic             BUSY,
  output logic             DONE
);

  // Counter widths, never narrower than one bit.
  localparam int BW = (WIDTH > 1)      ? $clog2(WIDTH)      : 1;
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_ZERO = BW'(0);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CYC_ONE  = CW'(1);
  localparam logic [CW-1:0] CYC_ZERO = CW'(0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
`ifdef TX_PARITY_EN
    PAR   = 3'd3,
`endif
    STOP  = 3'd4
  } state_t;

`ifdef TX_PARITY_EN
  // Even parity accumulates as a running XOR of the bits already sent.
  function automatic logic parity_step(input logic acc, input logic sent_bit);
    return acc ^ sent_bit;
  endfunction
`endif

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   shift_r;
  logic [WIDTH-1:0]   shift_s;
  logic [BW-1:0]      bit_cnt_r;
  logic [BW-1:0]      bit_cnt_s;
  logic [CW-1:0]      cyc_cnt_r;
  logic [CW-1:0]      cyc_cnt_s;
`ifdef TX_PARITY_EN
  logic               par_r;
  logic               par_s;
`endif
  logic               q_r;
  logic               q_s;
  logic               busy_r;
  logic               busy_s;
  logic               done_r;
  logic               done_s;
  logic               bit_end_s;

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    bit_cnt_s = bit_cnt_r;
    cyc_cnt_s = cyc_cnt_r;
`ifdef TX_PARITY_EN
    par_s     = par_r;
`endif
    done_s    = 1'b0;
    q_s       = 1'b1;
    busy_s    = 1'b0;

    // Last cycle of the current bit slot; always true when BIT_CYCLES is 1.
    bit_end_s = (cyc_cnt_r == CYC_LAST);

    // Cycle counter runs in every busy state and wraps at each slot end.
    if (state_r != IDLE) begin
      if (bit_end_s) begin
        cyc_cnt_s = CYC_ZERO;
      end else begin
        cyc_cnt_s = cyc_cnt_r + CYC_ONE;
      end
    end else begin
      cyc_cnt_s = CYC_ZERO;
    end

    case (state_r)
      IDLE: begin
        if (LOAD) begin
          state_s   = START;
          shift_s   = DIN;
          bit_cnt_s = BIT_ZERO;
          cyc_cnt_s = CYC_ZERO;
`ifdef TX_PARITY_EN
          par_s     = 1'b0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_s = shift_r >> 1;
`ifdef TX_PARITY_EN
          par_s   = parity_step(par_r, shift_r[0]);
`endif
          if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_s = BIT_ZERO;
`ifdef TX_PARITY_EN
            state_s   = PAR;
`else
            state_s   = STOP;
`endif
          end else begin
            bit_cnt_s = bit_cnt_r + BIT_ONE;
            state_s   = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef TX_PARITY_EN
      PAR: begin
        if (bit_end_s) begin
          state_s = STOP;
        end else begin
          state_s = PAR;
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s   = IDLE;
        bit_cnt_s = BIT_ZERO;
        cyc_cnt_s = CYC_ZERO;
      end
    endcase

    // Outputs are decoded from the next state so the registered Q/BUSY
    // line up with the state they describe, with no input-to-output path.
    case (state_s)
      IDLE: begin
        q_s    = 1'b1;
        busy_s = 1'b0;
      end
      START: begin
        q_s    = 1'b0;
        busy_s = 1'b1;
      end
      DATA: begin
        q_s    = shift_s[0];
        busy_s = 1'b1;
      end
`ifdef TX_PARITY_EN
      PAR: begin
        q_s    = par_s;
        busy_s = 1'b1;
      end
`endif
      STOP: begin
        q_s    = 1'b1;
        busy_s = 1'b1;
      end
      default: begin
        q_s    = 1'b1;
        busy_s = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; CLR aborts to an idle-high line.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_r   <= IDLE;
      shift_r   <= {WIDTH{1'b0}};
      bit_cnt_r <= BIT_ZERO;
      cyc_cnt_r <= CYC_ZERO;
`ifdef TX_PARITY_EN
      par_r     <= 1'b0;
`endif
      q_r       <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      bit_cnt_r <= bit_cnt_s;
      cyc_cnt_r <= cyc_cnt_s;
`ifdef TX_PARITY_EN
      par_r     <= par_s;
`endif
      q_r       <= q_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign Q    = q_r;
  assign BUSY = busy_r;
  assign DONE = done_r;

endmodule
